inst_fetch_queue: RTL
=====================

// Module: inst_fetch_queue
// PURPOSE
//  Instruction fetch stage feeding the decode/control path. Owns the fetch PC and
//  drives a req/ack word-read port on instruction memory, one request outstanding.
//  Buffers fetched words with their PCs in a DEPTH-entry FIFO for decode (valid/ready).
//  Branch/jump redirects flush the FIFO; a response already in flight is dropped.
// PARAMETERS
//  DEPTH     4             FIFO entries (power of two, >=2)
//  PTR_W     2             log2(DEPTH)
//  RESET_PC  32'h00000000  fetch PC after reset (word aligned)
// PORTS
//  clock          in   1   rising-edge clock
//  reset          in   1   synchronous, active-high reset
//  imem_req       out  1   read request; held until imem_ack
//  imem_addr      out  32  byte address of requested word (bits[1:0]=0)
//  imem_ack       in   1   response valid this cycle; sampled only while imem_req=1
//  imem_rdata     in   32  instruction word (big-endian assembled), valid with ack
//  redirect       in   1   branch/jump taken: flush and refetch
//  redirect_pc    in   32  new fetch PC; bits[1:0] ignored (forced 0)
//  inst_valid     out  1   FIFO head valid
//  inst_ready     in   1   decode accepts head this cycle
//  inst_word      out  32  head instruction
//  inst_pc        out  32  head PC
//  inst_pc_plus4  out  32  inst_pc + 4, mod 2^32
//  fifo_count     out  PTR_W+1  occupied entries, 0..DEPTH
// BEHAVIOUR
//  - Reset: state=IDLE, fetch_pc=RESET_PC, FIFO empty, imem_req=0,
//    inst_valid=0, fifo_count=0; inst_word/inst_pc/inst_pc_plus4=0.
//  - States: IDLE (no request), REQ (imem_req=1, imem_addr=fetch_pc),
//    DROP (imem_req=1, addr held; response will be discarded).
//  - imem_req/imem_addr are registered; imem_addr stays constant while req=1.
//  - IDLE->REQ when fifo_count<DEPTH after this cycle's pop.
//  - REQ & ack: push {imem_rdata, fetch_pc}; fetch_pc+=4 (wraps 32'hFFFFFFFC->0);
//    stay REQ if free space remains after push/pop, else IDLE.
//  - REQ & !ack: hold. Zero-wait ack gives one word per cycle.
//  - Pop when inst_valid & inst_ready; head moves next edge.
//  - Push+pop same cycle: count unchanged. Never push when full; never pop empty.
//  - Redirect (highest priority, any state): FIFO flushed (count=0, inst_valid=0
//    next cycle, no pop counted); fetch_pc<=redirect_pc&~3.
//    From REQ w/o ack -> DROP; from REQ with ack -> ack data discarded, -> REQ;
//    from IDLE -> REQ; in DROP -> stay DROP with new fetch_pc.
//  - DROP & ack: discard rdata, -> REQ (imem_addr=fetch_pc next cycle).
//  - Redirect latency: first new-PC request on the cycle after redirect (IDLE
//    or ack'd REQ), new word visible at inst_valid >=2 cycles after redirect.
//  - Reset mid-request: req drops next cycle; a late ack while req=0 is ignored.
//  - Outputs driven from FIFO head regs; no combinational path imem->inst_*.
// TESTING
//  1 Reset, ack same cycle as req, inst_ready=1 -> imem_addr 0,4,8,... one per
//    cycle; inst_pc 0,4,8 with inst_word=rdata; inst_pc_plus4=inst_pc+4.
//  2 inst_ready=0, zero-wait ack -> 4 pushes, fifo_count=4, imem_req=0;
//    raise ready 1 cycle -> count 3, req reasserts next cycle, addr=0x10.
//  3 ack delayed 3 cycles -> imem_req/addr stable 0x0 for 4 cycles; one entry.
//  4 redirect to 0x1C while REQ pending -> DROP; stale ack dropped; next req
//    addr 0x1C; inst_pc=0x1C first word out; count was 0 after flush.
//  5 redirect_pc=0x23 with FIFO full and pop same cycle -> count 0, addr 0x20.
//  6 RESET_PC=0xFFFFFFF8 -> addrs 0xFFFFFFF8, 0xFFFFFFFC, 0x0; reset mid-WAIT
//    -> req 0 next cycle, late ack ignored, restart at RESET_PC.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues one imem read at a time and
// buffers fetched words with their PCs in a small FIFO for decode.
module inst_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned PTR_W    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clock,
    input  logic             reset,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [31:0]      inst_word,
    output logic [31:0]      inst_pc,
    output logic [31:0]      inst_pc_plus4,
    output logic [PTR_W:0]   fifo_count
);

    typedef enum logic [1:0] {StIdle, StReq, StDrop} state_e;

    localparam logic [PTR_W:0] FullCnt = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] OneCnt  = (PTR_W + 1)'(1);

    state_e           r_state, w_state_d;
    logic [31:0]      r_fetch_pc, w_fetch_pc_d;
    logic [31:0]      r_imem_addr;
    logic [31:0]      r_word [DEPTH];
    logic [31:0]      r_pc   [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr;
    logic [PTR_W:0]   r_count, w_count_d;
    logic             w_push, w_pop;
    logic             w_unused;

    assign w_unused = ^redirect_pc[1:0];

    always_comb begin
        w_pop        = (r_count != '0) && inst_ready && !redirect;
        w_push       = (r_state == StReq) && imem_ack && !redirect;
        w_count_d    = r_count;
        w_state_d    = r_state;
        w_fetch_pc_d = r_fetch_pc;

        if (w_push && !w_pop) begin
            w_count_d = r_count + OneCnt;
        end else if (w_pop && !w_push) begin
            w_count_d = r_count - OneCnt;
        end

        if (redirect) begin
            // Flush; any ack arriving now belongs to the old stream and is dropped.
            w_count_d    = '0;
            w_fetch_pc_d = {redirect_pc[31:2], 2'b00};
            unique case (r_state)
                StIdle:  w_state_d = StReq;
                StReq:   w_state_d = imem_ack ? StReq : StDrop;
                StDrop:  w_state_d = imem_ack ? StReq : StDrop;
                default: w_state_d = StIdle;
            endcase
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_count_d < FullCnt) w_state_d = StReq;
                end
                StReq: begin
                    if (imem_ack) begin
                        w_fetch_pc_d = r_fetch_pc + 32'd4;
                        w_state_d    = (w_count_d < FullCnt) ? StReq : StIdle;
                    end
                end
                StDrop: begin
                    if (imem_ack) w_state_d = StReq;
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= StIdle;
            r_fetch_pc  <= RESET_PC;
            r_imem_addr <= RESET_PC;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
        end else begin
            r_state    <= w_state_d;
            r_fetch_pc <= w_fetch_pc_d;
            r_count    <= w_count_d;
            // Address only moves when a fresh request is issued, so it is stable under req.
            if (w_state_d == StReq) r_imem_addr <= w_fetch_pc_d;
            if (redirect) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_word[r_wr_ptr] <= imem_rdata;
            r_pc[r_wr_ptr]   <= r_fetch_pc;
        end
    end

    assign imem_req      = (r_state != StIdle);
    assign imem_addr     = r_imem_addr;
    assign fifo_count    = r_count;
    assign inst_valid    = (r_count != '0);
    // Head fields read as zero while empty so reset/flush never expose stale entries.
    assign inst_word     = inst_valid ? r_word[r_rd_ptr] : 32'h0;
    assign inst_pc       = inst_valid ? r_pc[r_rd_ptr] : 32'h0;
    assign inst_pc_plus4 = inst_valid ? (r_pc[r_rd_ptr] + 32'd4) : 32'h0;

endmodule
